// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] oh2bin(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] b;
    b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) b = b | SEL_W'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the requesting agents (master) and the arbiter (slave).
interface mux4_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             switch_p;

  modport master (output req, input grant, sel, valid, switch_p);
  modport slave  (input req, output grant, sel, valid, switch_p);

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first unmasked request at or after ptr, wrapping 3 -> 0.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [N_REQ-1:0] pick_oh,
  output logic [SEL_W-1:0] pick_idx,
  output logic             any
);

  logic [N_REQ-1:0] masked;
  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    masked  = req & ~excl;
    pick_oh = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && masked[idx]) begin
        found        = 1'b1;
        pick_oh[idx] = 1'b1;
      end
    end
    any      = |masked;
    pick_idx = oh2bin(pick_oh);
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux; holds a grant while requested, pre-empts after MAX_HOLD.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                clock,
  input  logic                reset,
  mux4_rr_arbiter_if.slave    bus
);
  import mux_arb_pkg::*;

  localparam int unsigned CNT_W      = 8;
  localparam bit          PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] hold_q;
  logic [N_REQ-1:0] grant_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;
  logic             switch_q;

  logic             owner_req;
  logic             others;
  logic             preempt;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_excl;
  logic [N_REQ-1:0] pick_oh;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  // While granted, the scan always restarts just past the current owner.
  always_comb begin
    owner_req = |(bus.req & grant_q);
    others    = |(bus.req & ~grant_q);
    next_ptr  = sel_q + SEL_W'(1);
    preempt   = (state_q == ST_GRANTED) && owner_req && others &&
                PREEMPT_EN && (hold_q == HOLD_LAST);
    pick_ptr  = (state_q == ST_GRANTED) ? next_ptr : ptr_q;
    pick_excl = preempt ? grant_q : '0;
  end

  rr_pick4 u_pick (
    .req      (bus.req),
    .ptr      (pick_ptr),
    .excl     (pick_excl),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      hold_q   <= '0;
      grant_q  <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      switch_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q  <= pick_oh;
            sel_q    <= pick_idx;
            valid_q  <= 1'b1;
            switch_q <= 1'b1;
            hold_q   <= '0;
            state_q  <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (!owner_req) begin
            ptr_q  <= next_ptr;
            hold_q <= '0;
            if (pick_any) begin
              grant_q  <= pick_oh;
              sel_q    <= pick_idx;
              switch_q <= 1'b1;
            end else begin
              grant_q <= '0;
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (preempt) begin
            ptr_q    <= next_ptr;
            grant_q  <= pick_oh;
            sel_q    <= pick_idx;
            switch_q <= 1'b1;
            hold_q   <= '0;
          end else if (others && PREEMPT_EN) begin
            if (hold_q != HOLD_LAST) hold_q <= hold_q + CNT_W'(1);
          end else begin
            hold_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.valid    = valid_q;
  assign bus.switch_p = switch_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (MAX_HOLD=8) driving a shared 4:1 mux from sel.
module tb_mux4_rr_arbiter;

  logic clock;
  logic reset;
  int   passed;
  int   total;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mux_in [4];
  logic [7:0] mux_out;
  logic [7:0] obs;

  assign mux_out = mux_in[bus.sel];
  assign obs     = {bus.grant, bus.sel, bus.valid, bus.switch_p};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.req = 4'b1111;
    tick();
    total++;
    if (obs !== 8'b0000_00_0_0) $display("FAIL reset_with_req got=%b want=%b", obs, 8'b0000_00_0_0);
    else passed++;
    bus.req = 4'b0000;
    tick();
    total++;
    if (obs !== 8'b0000_00_0_0) $display("FAIL reset_idle got=%b want=%b", obs, 8'b0000_00_0_0);
    else passed++;
    reset = 1'b0;
    tick();
    total++;
    if (obs !== 8'b0000_00_0_0) $display("FAIL idle_no_req got=%b want=%b", obs, 8'b0000_00_0_0);
    else passed++;
  endtask

  task automatic test_rr_cycle();
    logic [7:0] exp;
    int         owner;
    do_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      tick();
      owner = (c / 8) % 4;
      exp   = {4'(1 << owner), 2'(owner), 1'b1, (c % 8 == 0)};
      total++;
      if (obs !== exp) $display("FAIL rr_cycle c=%0d got=%b want=%b", c, obs, exp);
      else passed++;
    end
  endtask

  task automatic test_single_and_idle();
    logic [7:0] exp;
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick();
      exp = {4'b0100, 2'd2, 1'b1, (c == 0)};
      total++;
      if (obs !== exp) $display("FAIL single c=%0d got=%b want=%b", c, obs, exp);
      else passed++;
    end
    total++;
    if (mux_out !== 8'h33) $display("FAIL mux_path got=%h want=%h", mux_out, 8'h33);
    else passed++;
    bus.req = 4'b0000;
    tick();
    total++;
    if (obs !== 8'b0000_10_0_0) $display("FAIL release_idle got=%b want=%b", obs, 8'b0000_10_0_0);
    else passed++;
    tick();
    total++;
    if (obs !== 8'b0000_10_0_0) $display("FAIL stay_idle got=%b want=%b", obs, 8'b0000_10_0_0);
    else passed++;
    bus.req = 4'b1111;
    tick();
    total++;
    if (obs !== 8'b1000_11_1_1) $display("FAIL ptr_after_idle got=%b want=%b", obs, 8'b1000_11_1_1);
    else passed++;
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    bus.req = 4'b0010;
    tick();
    total++;
    if (obs !== 8'b0010_01_1_1) $display("FAIL b2b_first got=%b want=%b", obs, 8'b0010_01_1_1);
    else passed++;
    bus.req = 4'b1010;
    tick();
    total++;
    if (obs !== 8'b0010_01_1_0) $display("FAIL b2b_hold got=%b want=%b", obs, 8'b0010_01_1_0);
    else passed++;
    bus.req = 4'b1000;
    tick();
    total++;
    if (obs !== 8'b1000_11_1_1) $display("FAIL b2b_handoff got=%b want=%b", obs, 8'b1000_11_1_1);
    else passed++;
    bus.req = 4'b1011;
    tick();
    total++;
    if (obs !== 8'b1000_11_1_0) $display("FAIL wrap_hold got=%b want=%b", obs, 8'b1000_11_1_0);
    else passed++;
    bus.req = 4'b0011;
    tick();
    total++;
    if (obs !== 8'b0001_00_1_1) $display("FAIL wrap_to_0 got=%b want=%b", obs, 8'b0001_00_1_1);
    else passed++;
  endtask

  task automatic test_hold_clear();
    logic [7:0] exp;
    do_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0011;
    repeat (4) tick();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0011;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp = (c < 8) ? 8'b0001_00_1_0 : 8'b0010_01_1_1;
      total++;
      if (obs !== exp) $display("FAIL hold_clear c=%0d got=%b want=%b", c, obs, exp);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0011;
    repeat (5) tick();
    total++;
    if (obs !== 8'b0010_01_1_0) $display("FAIL mid_pre got=%b want=%b", obs, 8'b0010_01_1_0);
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if (obs !== 8'b0000_00_0_0) $display("FAIL mid_reset got=%b want=%b", obs, 8'b0000_00_0_0);
    else passed++;
    reset   = 1'b0;
    bus.req = 4'b0010;
    tick();
    total++;
    if (obs !== 8'b0010_01_1_1) $display("FAIL post_reset got=%b want=%b", obs, 8'b0010_01_1_1);
    else passed++;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    reset   = 1'b1;
    bus.req = 4'b0000;
    mux_in[0] = 8'h11;
    mux_in[1] = 8'h22;
    mux_in[2] = 8'h33;
    mux_in[3] = 8'h44;
    test_reset();
    test_rr_cycle();
    test_single_and_idle();
    test_back_to_back_wrap();
    test_hold_clear();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
